phase_accumulate: RTL and testbench

Multi-channel phase-difference extractor and run averager placed downstream of per-channel peak detection in the phase extraction chain. It accepts one packet per run holding the detected peak (frequency, magnitude, phase) of every antenna channel, and computes each channel's phase relative to channel 0, wrapped to (-180°, +180°]. Deltas and magnitudes are averaged over RUNS valid packets, then emitted as one result packet of CHANNELS words. All data words are 32-bit two's complement fixed point (FP) with 8 fractional bits.

---
 rtl/phase_accumulate.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_phase_accumulate.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulate.sv
// Multi-channel phase-difference extractor: per-packet deltas vs channel 0, averaged over RUNS packets.
// Optional per-channel frequency agreement check enabled by defining PHASE_ACCUMULATE_FREQ_CHECK_EN.
module phase_accumulate #(
  parameter int CHANNELS = 4,
  parameter int RUNS     = 8,
  parameter int MAG_MIN  = 0,
  parameter int FREQ_TOL = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sink_sop,
  input  logic                        sink_eop,
  input  logic                        sink_valid,
  output logic                        sink_ready,
  input  logic signed [31:0]          sink_freq,
  input  logic signed [31:0]          sink_mag,
  input  logic signed [31:0]          sink_phase,
  output logic                        source_sop,
  output logic                        source_eop,
  output logic                        source_valid,
  input  logic                        source_ready,
  output logic [$clog2(CHANNELS)-1:0] source_channel,
  output logic signed [31:0]          source_delta,
  output logic signed [31:0]          source_mag,
  output logic signed [31:0]          source_freq,
  output logic                        error,
  output logic                        reject
);

  localparam int DATA_W    = 32;
  localparam int LOG2_RUNS = $clog2(RUNS);
  localparam int ACC_W     = DATA_W + LOG2_RUNS;
  localparam int CH_W      = $clog2(CHANNELS);
  localparam int CNT_W     = $clog2(CHANNELS + 1);
  localparam int RC_W      = $clog2(RUNS + 1);

  localparam logic [1:0] S_WAIT_SOP = 2'd0;
  localparam logic [1:0] S_COLLECT  = 2'd1;
  localparam logic [1:0] S_EMIT     = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHANNELS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHANNELS - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RUNS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  localparam logic signed [DATA_W-1:0] MAG_MIN_S  = DATA_W'(MAG_MIN);
  localparam logic signed [DATA_W:0]   FREQ_TOL_S = (DATA_W + 1)'(FREQ_TOL);

`ifdef PHASE_ACCUMULATE_FREQ_CHECK_EN
  localparam bit FREQ_CHECK = 1'b1;
`else
  localparam bit FREQ_CHECK = 1'b0;
`endif

  // Fold a raw difference of two (-180,+180] phases back into (-180,+180].
  function automatic logic signed [DATA_W-1:0] wrap_delta(input logic signed [DATA_W:0] d);
    logic signed [DATA_W:0] w;
    if (d > 33'sd46080)
      w = d - 33'sd92160;
    else if (d <= -33'sd46080)
      w = d + 33'sd92160;
    else
      w = d;
    return DATA_W'(w);
  endfunction

  function automatic logic signed [DATA_W-1:0] run_average(input logic signed [ACC_W-1:0] sum);
    return DATA_W'(sum >>> LOG2_RUNS);
  endfunction

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [RC_W-1:0]           run_cnt_q, run_cnt_d;
  logic signed [DATA_W-1:0]  phase0_q, phase0_d;
  logic signed [DATA_W-1:0]  freq0_q, freq0_d;
  logic signed [DATA_W-1:0]  stage_delta_q [CHANNELS];
  logic signed [DATA_W-1:0]  stage_delta_d [CHANNELS];
  logic signed [DATA_W-1:0]  stage_mag_q [CHANNELS];
  logic signed [DATA_W-1:0]  stage_mag_d [CHANNELS];
  logic                      mag_bad_q, mag_bad_d;
  logic                      freq_bad_q, freq_bad_d;
  logic                      commit_q, commit_d;
  logic signed [ACC_W-1:0]   acc_delta_q [CHANNELS];
  logic signed [ACC_W-1:0]   acc_delta_d [CHANNELS];
  logic signed [ACC_W-1:0]   acc_mag_q [CHANNELS];
  logic signed [ACC_W-1:0]   acc_mag_d [CHANNELS];
  logic signed [ACC_W-1:0]   acc_freq_q, acc_freq_d;
  logic                      src_valid_q, src_valid_d;
  logic                      src_sop_q, src_sop_d;
  logic                      src_eop_q, src_eop_d;
  logic [CH_W-1:0]           src_ch_q, src_ch_d;
  logic signed [DATA_W-1:0]  src_delta_q, src_delta_d;
  logic signed [DATA_W-1:0]  src_mag_q, src_mag_d;
  logic signed [DATA_W-1:0]  src_freq_q, src_freq_d;
  logic                      error_q, error_d;
  logic                      reject_q, reject_d;

  logic                      beat_acc;
  logic signed [DATA_W:0]    phase_diff;
  logic signed [DATA_W:0]    freq_diff;
  logic signed [DATA_W-1:0]  beat_delta;
  logic                      mag_low;
  logic                      freq_far;
  logic                      load_en;
  logic [CH_W-1:0]           emit_idx;

  assign sink_ready     = !reset && (state_q != S_EMIT);
  assign source_valid   = src_valid_q;
  assign source_sop     = src_sop_q;
  assign source_eop     = src_eop_q;
  assign source_channel = src_ch_q;
  assign source_delta   = src_delta_q;
  assign source_mag     = src_mag_q;
  assign source_freq    = src_freq_q;
  assign error          = error_q;
  assign reject         = reject_q;

  assign beat_acc   = sink_valid && sink_ready;
  assign phase_diff = (DATA_W + 1)'(sink_phase) - (DATA_W + 1)'(phase0_q);
  assign freq_diff  = (DATA_W + 1)'(sink_freq) - (DATA_W + 1)'(freq0_q);
  assign beat_delta = wrap_delta(phase_diff);
  assign mag_low    = sink_mag < MAG_MIN_S;
  assign freq_far   = FREQ_CHECK && ((freq_diff > FREQ_TOL_S) || (freq_diff < -FREQ_TOL_S));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    run_cnt_d     = run_cnt_q;
    phase0_d      = phase0_q;
    freq0_d       = freq0_q;
    stage_delta_d = stage_delta_q;
    stage_mag_d   = stage_mag_q;
    mag_bad_d     = mag_bad_q;
    freq_bad_d    = freq_bad_q;
    commit_d      = 1'b0;
    acc_delta_d   = acc_delta_q;
    acc_mag_d     = acc_mag_q;
    acc_freq_d    = acc_freq_q;
    src_valid_d   = src_valid_q;
    src_sop_d     = src_sop_q;
    src_eop_d     = src_eop_q;
    src_ch_d      = src_ch_q;
    src_delta_d   = src_delta_q;
    src_mag_d     = src_mag_q;
    src_freq_d    = src_freq_q;
    error_d       = 1'b0;
    reject_d      = 1'b0;
    load_en       = 1'b0;
    emit_idx      = '0;

    // Accumulate stage: the packet staged by the previous eop beat
    if (commit_q) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_delta_d[i] = acc_delta_q[i] + ACC_W'(stage_delta_q[i]);
        acc_mag_d[i]   = acc_mag_q[i] + ACC_W'(stage_mag_q[i]);
      end
      acc_freq_d = acc_freq_q + ACC_W'(freq0_q);
      run_cnt_d  = run_cnt_q + 1'b1;
    end

    case (state_q)
      S_WAIT_SOP, S_COLLECT: begin
        if (beat_acc) begin
          if (sink_sop) begin
            // A sop always restarts collection, abandoning any partial packet.
            error_d          = (state_q == S_COLLECT) || sink_eop;
            phase0_d         = sink_phase;
            freq0_d          = sink_freq;
            stage_delta_d[0] = '0;
            stage_mag_d[0]   = sink_mag;
            mag_bad_d        = mag_low;
            freq_bad_d       = 1'b0;
            if (sink_eop) begin
              state_d = S_WAIT_SOP;
              cnt_d   = '0;
            end else begin
              state_d = S_COLLECT;
              cnt_d   = CNT_W'(1);
            end
          end else if ((state_q == S_WAIT_SOP) || (cnt_q == CNT_FULL)) begin
            error_d = 1'b1;
            state_d = S_WAIT_SOP;
            cnt_d   = '0;
          end else begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (CNT_W'(i) == cnt_q) begin
                stage_delta_d[i] = beat_delta;
                stage_mag_d[i]   = sink_mag;
              end
            end
            mag_bad_d  = mag_bad_q | mag_low;
            freq_bad_d = freq_bad_q | freq_far;
            cnt_d      = cnt_q + 1'b1;
            if (sink_eop) begin
              cnt_d   = '0;
              state_d = S_WAIT_SOP;
              if (cnt_q != CNT_LAST)
                error_d = 1'b1;
              else if (mag_bad_q || mag_low || freq_bad_q || freq_far)
                reject_d = 1'b1;
              else begin
                commit_d = 1'b1;
                if (run_cnt_q == RC_LAST)
                  state_d = S_EMIT;
              end
            end
          end
        end
      end

      S_EMIT: begin
        if (commit_q) begin
          load_en  = 1'b1;
          emit_idx = '0;
        end else if (src_valid_q && source_ready) begin
          if (src_ch_q == CH_LAST) begin
            src_valid_d = 1'b0;
            src_sop_d   = 1'b0;
            src_eop_d   = 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
              acc_delta_d[i] = '0;
              acc_mag_d[i]   = '0;
            end
            acc_freq_d = '0;
            run_cnt_d  = '0;
            state_d    = S_WAIT_SOP;
          end else begin
            load_en  = 1'b1;
            emit_idx = src_ch_q + 1'b1;
          end
        end
      end

      default: state_d = S_WAIT_SOP;
    endcase

    // Output word register: averages come from the post-accumulate sums
    if (load_en) begin
      src_valid_d = 1'b1;
      src_ch_d    = emit_idx;
      src_sop_d   = (emit_idx == '0);
      src_eop_d   = (emit_idx == CH_LAST);
      src_freq_d  = run_average(acc_freq_d);
      for (int i = 0; i < CHANNELS; i++) begin
        if (CH_W'(i) == emit_idx) begin
          src_delta_d = run_average(acc_delta_d[i]);
          src_mag_d   = run_average(acc_mag_d[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT_SOP;
      cnt_q       <= '0;
      run_cnt_q   <= '0;
      phase0_q    <= '0;
      freq0_q     <= '0;
      mag_bad_q   <= 1'b0;
      freq_bad_q  <= 1'b0;
      commit_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        stage_delta_q[i] <= '0;
        stage_mag_q[i]   <= '0;
        acc_delta_q[i]   <= '0;
        acc_mag_q[i]     <= '0;
      end
      acc_freq_q  <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_ch_q    <= '0;
      src_delta_q <= '0;
      src_mag_q   <= '0;
      src_freq_q  <= '0;
      error_q     <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      run_cnt_q     <= run_cnt_d;
      phase0_q      <= phase0_d;
      freq0_q       <= freq0_d;
      mag_bad_q     <= mag_bad_d;
      freq_bad_q    <= freq_bad_d;
      commit_q      <= commit_d;
      stage_delta_q <= stage_delta_d;
      stage_mag_q   <= stage_mag_d;
      acc_delta_q   <= acc_delta_d;
      acc_mag_q     <= acc_mag_d;
      acc_freq_q    <= acc_freq_d;
      src_valid_q   <= src_valid_d;
      src_sop_q     <= src_sop_d;
      src_eop_q     <= src_eop_d;
      src_ch_q      <= src_ch_d;
      src_delta_q   <= src_delta_d;
      src_mag_q     <= src_mag_d;
      src_freq_q    <= src_freq_d;
      error_q       <= error_d;
      reject_q      <= reject_d;
    end
  end

endmodule

// File: tb/tb_phase_accumulate.sv
// Directed bench for phase_accumulate: packets drive a reference model whose result words are queued and popped on output.
module tb_phase_accumulate;
  localparam int CH = 4;
  localparam int RN = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sink_sop = 1'b0, sink_eop = 1'b0, sink_valid = 1'b0;
  logic               sink_ready;
  logic signed [31:0] sink_freq = '0, sink_mag = '0, sink_phase = '0;
  logic               source_sop, source_eop, source_valid;
  logic               source_ready = 1'b1;
  logic [1:0]         source_channel;
  logic signed [31:0] source_delta, source_mag, source_freq;
  logic               error, reject;

  phase_accumulate #(.CHANNELS(CH), .RUNS(RN), .MAG_MIN(512), .FREQ_TOL(256)) dut (
    .clk(clk), .reset(reset),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_freq(sink_freq), .sink_mag(sink_mag), .sink_phase(sink_phase),
    .source_sop(source_sop), .source_eop(source_eop), .source_valid(source_valid),
    .source_ready(source_ready), .source_channel(source_channel),
    .source_delta(source_delta), .source_mag(source_mag), .source_freq(source_freq),
    .error(error), .reject(reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int delta;
    int mag;
    int freq;
    bit sop;
    bit eop;
  } word_t;

  word_t  exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     err_cnt = 0;
  int     rej_cnt = 0;
  longint m_dsum[CH];
  longint m_msum[CH];
  longint m_fsum = 0;
  int     m_runs = 0;
  int     p_ph[CH];
  int     p_mag[CH];
  int     p_freq[CH];

  bit s_valid, s_sready, s_err, s_rej, s_sop, s_eop, beat_taken;
  int s_ch, s_delta, s_mag, s_freq;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int floor_div(input longint s);
    longint q;
    q = s / RN;
    if ((s % RN) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < CH; i++) begin
      m_dsum[i] = 0;
      m_msum[i] = 0;
    end
    m_fsum = 0;
    m_runs = 0;
  endtask

  task automatic mdl_add();
    int    d;
    word_t w;
    for (int i = 0; i < CH; i++) begin
      d = p_ph[i] - p_ph[0];
      while (d > 46080) d -= 92160;
      while (d <= -46080) d += 92160;
      m_dsum[i] += d;
      m_msum[i] += p_mag[i];
    end
    m_fsum += p_freq[0];
    m_runs++;
    if (m_runs == RN) begin
      for (int i = 0; i < CH; i++) begin
        w.ch    = i;
        w.delta = floor_div(m_dsum[i]);
        w.mag   = floor_div(m_msum[i]);
        w.freq  = floor_div(m_fsum);
        w.sop   = (i == 0);
        w.eop   = (i == CH - 1);
        exp_q.push_back(w);
      end
      mdl_clear();
    end
  endtask

  // One clock: sample everything on the falling edge, then advance past the rising edge.
  task automatic tick();
    word_t w;
    @(negedge clk);
    s_valid    = source_valid;
    s_sready   = sink_ready;
    s_err      = error;
    s_rej      = reject;
    s_sop      = source_sop;
    s_eop      = source_eop;
    s_ch       = int'(source_channel);
    s_delta    = source_delta;
    s_mag      = source_mag;
    s_freq     = source_freq;
    beat_taken = sink_valid && sink_ready;
    if (s_err) err_cnt++;
    if (s_rej) rej_cnt++;
    if (source_valid && source_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", exp_q.size(), 1);
      end else begin
        w = exp_q.pop_front();
        chk("word_channel", s_ch, w.ch);
        chk("word_delta", s_delta, w.delta);
        chk("word_mag", s_mag, w.mag);
        chk("word_freq", s_freq, w.freq);
        chk("word_sop", int'(s_sop), int'(w.sop));
        chk("word_eop", int'(s_eop), int'(w.eop));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input bit sop, input bit eop, input int fq, input int mg, input int ph);
    sink_sop   = sop;
    sink_eop   = eop;
    sink_freq  = fq;
    sink_mag   = mg;
    sink_phase = ph;
    sink_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (beat_taken) break;
    end
    if (!beat_taken) chk("beat_accept_timeout", int'(beat_taken), 1);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic send_pkt(input bit good);
    for (int i = 0; i < CH; i++)
      send_beat(i == 0, i == CH - 1, p_freq[i], p_mag[i], p_ph[i]);
    if (good) mdl_add();
  endtask

  task automatic set_pkt(input int ph0, input int ph1, input int ph2, input int ph3, input int mg, input int fq);
    p_ph[0] = ph0;
    p_ph[1] = ph1;
    p_ph[2] = ph2;
    p_ph[3] = ph3;
    for (int i = 0; i < CH; i++) begin
      p_mag[i]  = mg;
      p_freq[i] = fq;
    end
  endtask

  task automatic drain();
    source_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_complete", exp_q.size(), 0);
    tick();
    chk("idle_after_result", int'(s_valid), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sink_ready", int'(s_sready), 0);
    chk("rst_source_valid", int'(s_valid), 0);
    chk("rst_source_delta", s_delta, 0);
    chk("rst_source_mag", s_mag, 0);
    chk("rst_source_freq", s_freq, 0);
    chk("rst_error", int'(s_err), 0);
    chk("rst_reject", int'(s_rej), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int r0;
    int wa[4];
    int wb[4];
    mdl_clear();

    // Reset state
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();
    chk("sink_ready_after_reset", int'(s_sready), 1);

    // Basic averaging and result latency
    set_pkt(10 * 256, 40 * 256, -20 * 256, 100 * 256, 1000 * 256, 100 * 256);
    repeat (3) send_pkt(1'b1);
    send_pkt(1'b1);
    tick();
    chk("latency_cycle1_valid", int'(s_valid), 0);
    chk("emit_sink_ready", int'(s_sready), 0);
    tick();
    chk("latency_cycle2_valid", int'(s_valid), 1);
    drain();
    chk("basic_no_error", err_cnt, 0);
    chk("basic_no_reject", rej_cnt, 0);

    // Wrap boundaries
    wa = '{170, -170, 0, 90};
    wb = '{-170, 170, 180, -90};
    for (int k = 0; k < 4; k++) begin
      set_pkt(wa[k] * 256, wb[k] * 256, wa[k] * 256, -wa[k] * 256, 700 * 256, 2000 * 256);
      repeat (4) send_pkt(1'b1);
      drain();
    end

    // Framing errors
    e0 = err_cnt;
    r0 = rej_cnt;
    set_pkt(5 * 256, 15 * 256, 25 * 256, 35 * 256, 800 * 256, 300 * 256);
    send_beat(1'b1, 1'b0, p_freq[0], p_mag[0], p_ph[0]);
    send_beat(1'b0, 1'b0, p_freq[1], p_mag[1], p_ph[1]);
    send_beat(1'b0, 1'b1, p_freq[2], p_mag[2], p_ph[2]);
    tick();
    chk("err_eop_beat3", err_cnt, e0 + 1);
    send_beat(1'b1, 1'b0, p_freq[0], p_mag[0], p_ph[0]);
    for (int i = 1; i < CH; i++) send_beat(1'b0, 1'b0, p_freq[i], p_mag[i], p_ph[i]);
    send_beat(1'b0, 1'b0, p_freq[1], p_mag[1], p_ph[1]);
    tick();
    chk("err_missing_eop", err_cnt, e0 + 2);
    send_beat(1'b0, 1'b0, p_freq[1], p_mag[1], p_ph[1]);
    tick();
    chk("err_no_sop", err_cnt, e0 + 3);
    send_beat(1'b1, 1'b0, 999, 900 * 256, 77 * 256);
    send_pkt(1'b1);
    tick();
    chk("err_sop_beat2", err_cnt, e0 + 4);
    send_pkt(1'b1);
    send_pkt(1'b1);
    repeat (4) tick();
    chk("no_emit_after_3_good", int'(s_valid), 0);
    send_pkt(1'b1);
    drain();
    chk("framing_no_reject", rej_cnt, r0);

    // Magnitude (and optional frequency) rejection
    e0 = err_cnt;
    r0 = rej_cnt;
    set_pkt(-30 * 256, 60 * 256, 12 * 256, -150 * 256, 1200 * 256, 500 * 256);
    p_mag[2] = 256;
    send_pkt(1'b0);
    tick();
    chk("reject_mag", rej_cnt, r0 + 1);
    chk("reject_no_error", err_cnt, e0);
`ifdef PHASE_ACCUMULATE_FREQ_CHECK_EN
    set_pkt(-30 * 256, 60 * 256, 12 * 256, -150 * 256, 1200 * 256, 500 * 256);
    p_freq[1] = 500 * 256 + 512;
    send_pkt(1'b0);
    tick();
    chk("reject_freq", rej_cnt, r0 + 2);
    r0 = r0 + 1;
`endif
    set_pkt(-30 * 256, 60 * 256, 12 * 256, -150 * 256, 1200 * 256, 500 * 256);
    repeat (3) send_pkt(1'b1);
    repeat (4) tick();
    chk("no_emit_after_reject", int'(s_valid), 0);
    set_pkt(-31 * 256, 61 * 256, 13 * 256, -149 * 256, 512, 500 * 256);
    send_pkt(1'b1);
    drain();
    chk("mag_at_threshold_kept", rej_cnt, r0 + 1);

    // Backpressure on word 1
    for (int k = 0; k < 4; k++) begin
      set_pkt(k * 1000, k * 1000 + 3000, -k * 700, 12345, 600 * 256 + k * 5, 4000 + k);
      send_pkt(1'b1);
    end
    source_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (exp_q.size() == CH - 1) break;
      tick();
    end
    chk("bp_word0_taken", exp_q.size(), CH - 1);
    source_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid_held", int'(s_valid), 1);
      chk("bp_channel_held", s_ch, 1);
      chk("bp_delta_held", s_delta, exp_q[0].delta);
      chk("bp_mag_held", s_mag, exp_q[0].mag);
      chk("bp_sink_ready", int'(s_sready), 0);
    end
    chk("bp_no_word_lost", exp_q.size(), CH - 1);
    drain();

    // Reset after two committed packets
    set_pkt(100 * 256, -100 * 256, 50 * 256, 0, 3000 * 256, 7000);
    repeat (2) send_pkt(1'b1);
    tick();
    reset = 1'b1;
    mdl_clear();
    repeat (2) tick();
    check_reset_outputs();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_pkt(256, 256 + (k == 0 ? -3 : 1), 256 - 1 - k, -256 * k, 600 + 3 * k, 9000 + k);
      send_pkt(1'b1);
    end
    repeat (4) tick();
    chk("no_emit_after_reset_3", int'(s_valid), 0);
    set_pkt(256, 255, 300, 40000, 611, 9010);
    send_pkt(1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
